// File: rtl/cmd_frame_parser_pkg.sv
// Shared types and frame constants for the UART flight-command parser.
package drone_cmd_pkg;

  typedef enum logic [7:0] {
    IDLE    = 8'h00,
    TAKEOFF = 8'h01,
    HOVER   = 8'h02,
    FORWARD = 8'h03
  } action_t;

  localparam logic [7:0]  ACT_MAX     = FORWARD;
  localparam int unsigned FRAME_LEN   = 11;
  localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 2;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ACTION  = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    HUNT,
    BODY,
    CSUM
  } state_t;

  function automatic logic signed [15:0] clamp16(input logic signed [15:0] v,
                                                 input logic signed [15:0] lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte stream in, committed command out; master drives bytes, slave is the parser.
interface cmd_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  action;
  logic [15:0] target_height;
  logic [15:0] target_pitch;
  logic [15:0] target_roll;
  logic [15:0] target_yaw;
  logic        cmd_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        failsafe;

  modport master (
    output rx_data, rx_valid,
    input  action, target_height, target_pitch, target_roll, target_yaw,
           cmd_valid, err, err_code, failsafe
  );

  modport slave (
    input  rx_data, rx_valid,
    output action, target_height, target_pitch, target_roll, target_yaw,
           cmd_valid, err, err_code, failsafe
  );
endinterface

// File: rtl/cmd_watchdog.sv
// Link-loss watchdog: saturating idle counter, one-cycle expiry strobe; a kick clears it.
module cmd_watchdog #(
  parameter int unsigned WDT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick_i,
  output logic expire_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (kick_i) begin
      count_d = '0;
    end else if (count_q != WDT_CYCLES) begin
      count_d = count_q + 32'd1;
      if (count_q == WDT_CYCLES - 1) expire_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles 11-byte XOR-checksummed UART frames into clamped flight setpoints.
// Define CMD_WATCHDOG_EN to add the link-loss watchdog (failsafe output).
module cmd_frame_parser
  import drone_cmd_pkg::*;
#(
  parameter logic [7:0]         HEADER         = 8'hAA,
  parameter int unsigned        TIMEOUT_CYCLES = 50000,
  parameter logic signed [15:0] PITCH_LIMIT    = 16'sd1500,
  parameter logic signed [15:0] ROLL_LIMIT     = 16'sd1500
`ifdef CMD_WATCHDOG_EN
  , parameter int unsigned      WDT_CYCLES     = 25000000
`endif
) (
  input logic               clk,
  input logic               reset,
  cmd_frame_parser_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  buf_q [PAYLOAD_LEN];
  logic        store, commit, reject, wdt_expire;
  err_code_t   rej_code;

  logic [7:0]  action_q;
  logic [15:0] height_q, pitch_q, roll_q, yaw_q;
  logic        cmd_valid_q, err_q, failsafe_q;
  logic [1:0]  err_code_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    timer_d  = '0;
    store    = 1'b0;
    commit   = 1'b0;
    reject   = 1'b0;
    rej_code = ERR_NONE;
    case (state_q)
      HUNT: begin
        if (bus.rx_valid && bus.rx_data == HEADER) begin
          state_d = BODY;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      BODY, CSUM: begin
        // An arriving byte takes precedence over a timer expiring in the same cycle.
        if (bus.rx_valid) begin
          if (state_q == BODY) begin
            store = 1'b1;
            xor_d = xor_q ^ bus.rx_data;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'(PAYLOAD_LEN - 1)) state_d = CSUM;
          end else begin
            state_d = HUNT;
            if (bus.rx_data != xor_q) begin
              reject   = 1'b1;
              rej_code = ERR_CSUM;
            end else if (buf_q[0] > ACT_MAX) begin
              reject   = 1'b1;
              rej_code = ERR_ACTION;
            end else begin
              commit = 1'b1;
            end
          end
        end else if (timer_q == TIMEOUT_CYCLES - 1) begin
          state_d  = HUNT;
          reject   = 1'b1;
          rej_code = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      xor_q   <= '0;
      timer_q <= '0;
      for (int unsigned i = 0; i < PAYLOAD_LEN; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      timer_q <= timer_d;
      if (store) buf_q[idx_q] <= bus.rx_data;
    end
  end

`ifdef CMD_WATCHDOG_EN
  cmd_watchdog #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk      (clk),
    .reset    (reset),
    .kick_i   (commit),
    .expire_o (wdt_expire)
  );
`else
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      action_q    <= '0;
      height_q    <= '0;
      pitch_q     <= '0;
      roll_q      <= '0;
      yaw_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      failsafe_q  <= 1'b0;
    end else begin
      cmd_valid_q <= commit;
      err_q       <= reject;
      if (reject) err_code_q <= rej_code;
      if (commit) begin
        action_q   <= buf_q[0];
        height_q   <= {buf_q[1], buf_q[2]};
        pitch_q    <= clamp16({buf_q[3], buf_q[4]}, PITCH_LIMIT);
        roll_q     <= clamp16({buf_q[5], buf_q[6]}, ROLL_LIMIT);
        yaw_q      <= {buf_q[7], buf_q[8]};
        failsafe_q <= 1'b0;
      end else if (wdt_expire) begin
        action_q   <= IDLE;
        height_q   <= '0;
        pitch_q    <= '0;
        roll_q     <= '0;
        yaw_q      <= '0;
        failsafe_q <= 1'b1;
      end
    end
  end

  assign bus.action        = action_q;
  assign bus.target_height = height_q;
  assign bus.target_pitch  = pitch_q;
  assign bus.target_roll   = roll_q;
  assign bus.target_yaw    = yaw_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.err           = err_q;
  assign bus.err_code      = err_code_q;
  assign bus.failsafe      = failsafe_q;

endmodule
